// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode wait, execute, optional data
// memory access and writeback/retire, with a sticky trap on illegal decode or misaligned redirect.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  input  logic        branch_en,
  input  logic        jalr_en,
  input  logic        jal_en,
  input  logic        lui_en,
  input  logic        auipc_en,
  input  logic        reg_imm_en,
  input  logic        reg_reg_en,
  input  logic        load_en,
  input  logic        store_en,
  input  logic        fence_en,
  input  logic [31:0] next_pc,
  input  logic        branch_taken,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  input  logic        dmem_rsp_valid,
  output logic        alu_start,
  output logic        regfile_we,
  output logic [31:0] pc,
  output logic        retired,
  output logic [31:0] retire_count,
  output logic        illegal
);

  typedef enum logic [2:0] {
    FETCH_REQ, FETCH_WAIT, DECODE, EXECUTE, MEM_REQ, MEM_WAIT, WRITEBACK, TRAP
  } state_t;

  typedef struct packed {
    logic fence;
    logic store;
    logic load;
    logic reg_reg;
    logic reg_imm;
    logic auipc;
    logic lui;
    logic jal;
    logic jalr;
    logic branch;
  } cls_t;

  state_t     state;
  cls_t       cls;
  logic [9:0] en_bits;
  cls_t       en;
  logic       en_one;
  logic       redirect;
  logic       misalign;
  logic       wb;

  assign en_bits = {fence_en, store_en, load_en, reg_reg_en, reg_imm_en,
                    auipc_en, lui_en, jal_en, jalr_en, branch_en};
  assign en      = cls_t'(en_bits);
  assign en_one  = (en_bits != '0) && ((en_bits & (en_bits - 10'd1)) == '0);

  // Redirect decision uses the latched class; ALU inputs are only sampled in writeback.
  assign redirect = cls.jal | cls.jalr | (cls.branch & branch_taken);
  assign misalign = redirect && (next_pc[1:0] != 2'b00);
  assign wb       = (state == WRITEBACK);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= FETCH_REQ;
      pc           <= RESET_PC;
      instr        <= '0;
      retire_count <= '0;
      illegal      <= 1'b0;
      cls          <= '0;
    end else begin
      case (state)
        FETCH_REQ:  if (imem_req_ready) state <= FETCH_WAIT;
        FETCH_WAIT: if (imem_rsp_valid) begin
          instr <= imem_rsp_data;
          state <= DECODE;
        end
        DECODE:     state <= EXECUTE;
        EXECUTE: begin
          cls <= en;
          if (!en_one) begin
            state   <= TRAP;
            illegal <= 1'b1;
          end else if (en.load || en.store) begin
            state <= MEM_REQ;
          end else begin
            state <= WRITEBACK;
          end
        end
        MEM_REQ:    if (dmem_req_ready) state <= MEM_WAIT;
        MEM_WAIT:   if (dmem_rsp_valid) state <= WRITEBACK;
        WRITEBACK: begin
          if (misalign) begin
            state   <= TRAP;
            illegal <= 1'b1;
          end else begin
            pc           <= redirect ? next_pc : pc + 32'd4;
            retire_count <= retire_count + 32'd1;
            state        <= FETCH_REQ;
          end
        end
        TRAP:       illegal <= 1'b1;
        default:    state <= TRAP;
      endcase
    end
  end

  // Reset parks the FSM in FETCH_REQ, so the request is gated off while reset is held.
  assign imem_req_valid = reset_n && (state == FETCH_REQ);
  assign imem_addr      = pc;
  assign opcode         = instr[6:0];
  assign dmem_req_valid = (state == MEM_REQ);
  assign dmem_we        = (state == MEM_REQ) && cls.store;
  assign alu_start      = (state == EXECUTE);
  assign retired        = wb && !misalign && (cls != '0);
  assign regfile_we     = wb && !misalign &&
                          (cls.jal | cls.jalr | cls.lui | cls.auipc |
                           cls.reg_imm | cls.reg_reg | cls.load);

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer: per-instruction timelines are built from
// the handshake delays and checked cycle by cycle, plus directed literal checks.
module tb_core_sequencer;
  localparam logic [31:0] RPC = 32'hFFFF_FFF0;
  localparam int BR = 0, JALR = 1, JAL = 2, LUI = 3, AUIPC = 4, RIMM = 5,
                 RREG = 6, LD = 7, ST = 8, FN = 9;

  typedef struct {
    logic        ireq_rdy, irsp_v;
    logic [31:0] irsp_d;
    logic [9:0]  en;
    logic [31:0] npc;
    logic        bt, dreq_rdy, drsp_v;
    logic        e_ireq, e_dreq, e_dwe, e_alu, e_rfwe, e_ret, e_ill;
    logic [31:0] e_pc, e_cnt, e_instr;
  } cyc_t;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic        imem_req_valid, dmem_req_valid, dmem_we, alu_start, regfile_we, retired, illegal;
  logic [31:0] imem_addr, instr, pc, retire_count;
  logic [6:0]  opcode;

  cyc_t cur;
  cyc_t q[$];
  bit   chk_en;
  int   nvec, nerr, cyc_no, first_rfwe;
  logic [31:0] m_pc, m_cnt, m_instr;
  logic        m_ill;

  core_sequencer #(.RESET_PC(RPC)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(cur.ireq_rdy), .imem_addr(imem_addr),
    .imem_rsp_valid(cur.irsp_v), .imem_rsp_data(cur.irsp_d),
    .instr(instr), .opcode(opcode),
    .branch_en(cur.en[BR]), .jalr_en(cur.en[JALR]), .jal_en(cur.en[JAL]), .lui_en(cur.en[LUI]),
    .auipc_en(cur.en[AUIPC]), .reg_imm_en(cur.en[RIMM]), .reg_reg_en(cur.en[RREG]),
    .load_en(cur.en[LD]), .store_en(cur.en[ST]), .fence_en(cur.en[FN]),
    .next_pc(cur.npc), .branch_taken(cur.bt),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(cur.dreq_rdy), .dmem_we(dmem_we),
    .dmem_rsp_valid(cur.drsp_v),
    .alu_start(alu_start), .regfile_we(regfile_we),
    .pc(pc), .retired(retired), .retire_count(retire_count), .illegal(illegal)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic cyc_t zrec();
    cyc_t c;
    c = '{default: '0};
    return c;
  endfunction

  // Random noise on every input; expectations default to "no pulses", current model state.
  function automatic cyc_t base();
    cyc_t c;
    c.ireq_rdy = 1'($urandom); c.irsp_v = 1'($urandom); c.irsp_d = $urandom;
    c.en = 10'($urandom); c.npc = $urandom; c.bt = 1'($urandom);
    c.dreq_rdy = 1'($urandom); c.drsp_v = 1'($urandom);
    c.e_ireq = 0; c.e_dreq = 0; c.e_dwe = 0; c.e_alu = 0; c.e_rfwe = 0; c.e_ret = 0;
    c.e_ill = m_ill; c.e_pc = m_pc; c.e_cnt = m_cnt; c.e_instr = m_instr;
    return c;
  endfunction

  // Timeline of one instruction from its handshake delays.
  task automatic gen(input logic [31:0] iw, input logic [9:0] en, input logic [31:0] npc,
                     input logic bt, input int ird, input int rsd, input int drd,
                     input int dsd, input bit abort_mw);
    cyc_t c;
    logic redir;
    if (m_ill) begin
      repeat (6) q.push_back(base());
      return;
    end
    for (int i = 0; i <= ird; i++) begin
      c = base(); c.ireq_rdy = (i == ird); c.e_ireq = 1; q.push_back(c);
    end
    for (int i = 0; i <= rsd; i++) begin
      c = base(); c.irsp_v = (i == rsd); c.irsp_d = iw; q.push_back(c);
    end
    m_instr = iw;
    q.push_back(base());
    c = base(); c.en = en; c.e_alu = 1; q.push_back(c);
    if ($countones(en) != 1) begin
      m_ill = 1;
      return;
    end
    if (en[LD] || en[ST]) begin
      for (int i = 0; i <= drd; i++) begin
        c = base(); c.dreq_rdy = (i == drd); c.e_dreq = 1; c.e_dwe = en[ST]; q.push_back(c);
      end
      for (int i = 0; i <= dsd; i++) begin
        c = base(); c.drsp_v = (i == dsd) && !abort_mw; q.push_back(c);
        if (abort_mw) return;
      end
    end
    c = base(); c.npc = npc; c.bt = bt;
    redir = en[JAL] | en[JALR] | (en[BR] & bt);
    if (redir && npc[1:0] != 2'b00) begin
      q.push_back(c);
      m_ill = 1;
      return;
    end
    c.e_ret = 1; c.e_rfwe = !(en[ST] | en[BR] | en[FN]);
    q.push_back(c);
    m_pc  = redir ? npc : m_pc + 32'd4;
    m_cnt = m_cnt + 32'd1;
  endtask

  // Entered and left at posedge+1.
  task automatic play();
    while (q.size() > 0) begin
      cur = q.pop_front();
      chk_en = 1;
      @(posedge clock); #1;
    end
    chk_en = 0;
  endtask

  task automatic do_reset();
    chk_en = 0; cur = zrec(); reset_n = 0;
    #1;
    chk("rst_pc", pc, RPC);
    chk("rst_cnt", retire_count, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_imem_req", 32'(imem_req_valid), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req_valid), 32'd0);
    chk("rst_pulses", {28'd0, dmem_we, alu_start, regfile_we, retired}, 32'd0);
    m_pc = RPC; m_cnt = 0; m_instr = 0; m_ill = 0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1; cyc_no = 0; first_rfwe = 0;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      cyc_no++;
      if (regfile_we && first_rfwe == 0) first_rfwe = cyc_no;
      chk("imem_req_valid", 32'(imem_req_valid), 32'(cur.e_ireq));
      chk("imem_addr", imem_addr, cur.e_pc);
      chk("pc", pc, cur.e_pc);
      chk("retire_count", retire_count, cur.e_cnt);
      chk("instr", instr, cur.e_instr);
      chk("opcode", 32'(opcode), 32'(cur.e_instr[6:0]));
      chk("illegal", 32'(illegal), 32'(cur.e_ill));
      chk("dmem_req_valid", 32'(dmem_req_valid), 32'(cur.e_dreq));
      chk("dmem_we", 32'(dmem_we), 32'(cur.e_dwe));
      chk("alu_start", 32'(alu_start), 32'(cur.e_alu));
      chk("regfile_we", 32'(regfile_we), 32'(cur.e_rfwe));
      chk("retired", 32'(retired), 32'(cur.e_ret));
    end
  end

  initial begin
    logic [9:0]  en;
    logic [31:0] npc;
    int          r, a, b;
    nvec = 0; nerr = 0; chk_en = 0; cyc_no = 0; first_rfwe = 0;
    cur = zrec(); reset_n = 0;
    m_pc = RPC; m_cnt = 0; m_instr = 0; m_ill = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("init_pc", pc, 32'hFFFF_FFF0);
    chk("init_cnt", retire_count, 32'd0);
    chk("init_imem_req", 32'(imem_req_valid), 32'd0);
    reset_n = 1;

    // reg-reg op, zero-wait memories
    gen(32'h0000_0033, 10'b1 << RREG, 32'h0, 1'b0, 0, 0, 0, 0, 0); play();
    chk("lat_nonmem_cycles", 32'(cyc_no), 32'd5);
    chk("lat_rfwe_cycle", 32'(first_rfwe), 32'd5);
    chk("lit_pc1", pc, 32'hFFFF_FFF4);
    chk("lit_cnt1", retire_count, 32'd1);

    // load with 3 stall cycles on dmem_req_ready
    cyc_no = 0;
    gen(32'h0000_2083, 10'b1 << LD, 32'h0, 1'b0, 0, 0, 3, 0, 0); play();
    chk("lit_load_cycles", 32'(cyc_no), 32'd10);
    chk("lit_pc2", pc, 32'hFFFF_FFF8);

    // pc wraps past 0xFFFFFFFC
    gen(32'h0000_0013, 10'b1 << RIMM, 32'h0, 1'b0, 0, 0, 0, 0, 0); play();
    chk("lit_pc3", pc, 32'hFFFF_FFFC);
    gen(32'h0000_0013, 10'b1 << RIMM, 32'h0, 1'b0, 0, 0, 0, 0, 0); play();
    chk("lit_pc_wrap", pc, 32'h0000_0000);

    // branch taken / not taken
    gen(32'h0000_0063, 10'b1 << BR, 32'h100, 1'b1, 1, 1, 0, 0, 0); play();
    chk("lit_br_taken", pc, 32'h0000_0100);
    gen(32'h0000_0063, 10'b1 << BR, 32'h200, 1'b0, 0, 2, 0, 0, 0); play();
    chk("lit_br_not_taken", pc, 32'h0000_0104);

    // misaligned jal target traps without retiring
    gen(32'h0000_006F, 10'b1 << JAL, 32'h102, 1'b0, 0, 0, 0, 0, 0);
    gen(32'h0, 10'b0, 32'h0, 1'b0, 0, 0, 0, 0, 0); play();
    chk("lit_jal_trap_pc", pc, 32'h0000_0104);
    chk("lit_jal_trap_cnt", retire_count, 32'd6);
    chk("lit_jal_trap_ill", 32'(illegal), 32'd1);
    do_reset();

    // no enable set
    gen(32'h0000_007F, 10'b0, 32'h0, 1'b0, 0, 0, 0, 0, 0);
    gen(32'h0, 10'b0, 32'h0, 1'b0, 0, 0, 0, 0, 0); play();
    chk("lit_opc7f_ill", 32'(illegal), 32'd1);
    chk("lit_opc7f_noreq", 32'(imem_req_valid), 32'd0);
    do_reset();

    // reset while waiting on dmem response, then a stale response arrives
    gen(32'h0000_2023, 10'b1 << ST, 32'h0, 1'b0, 0, 0, 1, 5, 1); play();
    do_reset();
    gen(32'h0000_0037, 10'b1 << LUI, 32'h0, 1'b0, 0, 0, 0, 0, 0);
    q[0].drsp_v = 1'b1;
    play();
    chk("lit_after_abort_pc", pc, 32'hFFFF_FFF4);

    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(99, 0);
      a = $urandom_range(9, 0);
      b = (a + $urandom_range(9, 1)) % 10;
      if (r < 4)      en = 10'b0;
      else if (r < 8) en = (10'b1 << a) | (10'b1 << b);
      else            en = 10'b1 << a;
      npc = $urandom;
      if ($urandom_range(9, 0) != 0) npc[1:0] = 2'b00;
      gen($urandom, en, npc, 1'($urandom), $urandom_range(3, 0), $urandom_range(3, 0),
          $urandom_range(3, 0), $urandom_range(3, 0), 0);
      play();
      if (m_ill) begin
        gen(32'h0, 10'b0, 32'h0, 1'b0, 0, 0, 0, 0, 0);
        play();
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 imem_req_valid  out  1  instruction fetch request; imem_req_ready  in  1  fetch request accepted.
REQ-005 imem_addr  out  32  fetch address, equals pc; imem_rsp_valid  in  1 / imem_rsp_data  in  32  fetch response.
REQ-006 instr  out  32  latched instruction; opcode  out  7  instr[6:0], drives the registered decoder.
REQ-007 Decoder enables, each in 1: branch_en, jalr_en, jal_en, lui_en, auipc_en, reg_imm_en, reg_reg_en, load_en, store_en, fence_en.
REQ-008 next_pc  in  32  ALU target address; branch_taken  in  1  ALU branch outcome.
REQ-009 dmem_req_valid  out  1; dmem_req_ready  in  1; dmem_we  out  1 (1=store); dmem_rsp_valid  in  1.
REQ-010 alu_start  out  1 and regfile_we  out  1, single-cycle pulses.
REQ-011 pc  out  32; retired  out  1 pulse; retire_count  out  32; illegal  out  1 sticky trap flag.

Function
REQ-012 States: FETCH_REQ, FETCH_WAIT, DECODE, EXECUTE, MEM_REQ, MEM_WAIT, WRITEBACK, TRAP.
REQ-013 FETCH_REQ: imem_req_valid=1, imem_addr=pc stable; imem_req_valid&imem_req_ready -> FETCH_WAIT; else hold.
REQ-014 FETCH_WAIT: imem_req_valid=0; imem_rsp_valid=1 -> instr<=imem_rsp_data, -> DECODE; imem_rsp_valid in any other state ignored.
REQ-015 DECODE: one wait cycle so registered decoder enables become valid; -> EXECUTE unconditionally.
REQ-016 EXECUTE: alu_start=1 for exactly this cycle; enables latched into internal class register.
REQ-017 EXECUTE, zero enables or more than one enable set -> TRAP.
REQ-018 EXECUTE, load_en or store_en -> MEM_REQ; any other single enable -> WRITEBACK.
REQ-019 MEM_REQ: dmem_req_valid=1, dmem_we=store class; valid held until dmem_req_ready; accept -> MEM_WAIT.
REQ-020 MEM_WAIT: dmem_req_valid=0; dmem_rsp_valid=1 -> WRITEBACK.
REQ-021 WRITEBACK, one cycle: regfile_we=1 unless class is store, branch or fence; retired=1; retire_count<=retire_count+1, wrapping mod 2^32.
REQ-022 WRITEBACK PC: jal, jalr, or branch with branch_taken -> pc<=next_pc; otherwise pc<=pc+4, wrapping mod 2^32; -> FETCH_REQ.
REQ-023 WRITEBACK with redirect and next_pc[1:0]!=0: pc unchanged, regfile_we=0, retired=0, count unchanged; -> TRAP.
REQ-024 TRAP: illegal=1, all request, pulse and strobe outputs 0; state held until reset.
REQ-025 Latency with zero-wait memories: non-memory instruction 5 cycles FETCH_REQ to FETCH_REQ; load/store 7 cycles.
REQ-026 instr, class register and pc are stable outside their update cycles; opcode always equals instr[6:0].

Reset
REQ-027 reset_n=0 forces, asynchronously: state=FETCH_REQ, pc=RESET_PC, instr=0, retire_count=0, illegal=0.
REQ-028 During reset, all req_valid, alu_start, regfile_we, retired, dmem_we = 0.
REQ-029 Reset mid-transaction abandons the transaction; responses arriving after reset release are ignored unless in the matching wait state.
REQ-030 First fetch request is asserted in the first clock cycle after reset_n rises, with imem_addr=RESET_PC.

Verification
REQ-031 Reset release, imem ready always, rsp 0x00000033 next cycle, reg_reg_en=1 -> regfile_we pulse in cycle 5, pc=0x4, retire_count=1.
REQ-032 Load 0x00002083, load_en=1, dmem_req_ready low 3 cycles -> dmem_req_valid held 4 cycles, dmem_we=0, regfile_we after rsp, pc+=4.
REQ-033 Branch 0x00000063, branch_taken=1, next_pc=0x100 -> pc=0x100, regfile_we=0; branch_taken=0 -> pc=old pc+4.
REQ-034 Opcode 0x7F with all enables 0 -> TRAP, illegal=1, no further imem_req_valid until reset_n pulsed low.
REQ-035 jal_en=1, next_pc=0x102 -> TRAP, pc unchanged, retire_count unchanged.
REQ-036 pc=0xFFFFFFFC non-branch -> pc=0x0; retire_count=0xFFFFFFFF retire -> 0; reset_n low in MEM_WAIT -> immediate FETCH_REQ at RESET_PC.
